// File: rtl/uart_key_decoder.sv
// Maps UART bytes to game commands: FWFT command queue plus per-direction hold mask.
// Optional KEY_CASE_FOLD_EN: uppercase W/S/A/D/J/K decode like their lowercase keys.
module uart_key_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 10000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [2:0]                    cmd_code,
  output logic [3:0]                    hold_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int ND = 4;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_UP      = 3'd1;
  localparam logic [2:0] C_DOWN    = 3'd2;
  localparam logic [2:0] C_LEFT    = 3'd3;
  localparam logic [2:0] C_RIGHT   = 3'd4;
  localparam logic [2:0] C_CONFIRM = 3'd5;
  localparam logic [2:0] C_CANCEL  = 3'd6;

  logic [FIFO_DEPTH-1:0][2:0] mem_q, mem_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       ovf_q, ovf_d;
  logic [7:0]                 drop_q, drop_d;
  logic [ND-1:0][HW-1:0]      hold_q, hold_d;

  logic [2:0]    key_code;
  logic [ND-1:0] key_dir;
  logic          mapped, full, push, pop;

  always_comb begin
    key_code = C_NONE;
    case (rx_data)
      8'h77: key_code = C_UP;
      8'h73: key_code = C_DOWN;
      8'h61: key_code = C_LEFT;
      8'h64: key_code = C_RIGHT;
      8'h20, 8'h6A: key_code = C_CONFIRM;
      8'h6B: key_code = C_CANCEL;
`ifdef KEY_CASE_FOLD_EN
      8'h57: key_code = C_UP;
      8'h53: key_code = C_DOWN;
      8'h41: key_code = C_LEFT;
      8'h44: key_code = C_RIGHT;
      8'h4A: key_code = C_CONFIRM;
      8'h4B: key_code = C_CANCEL;
`endif
      default: key_code = C_NONE;
    endcase
  end

  // Direction one-hot in hold_mask bit order {RIGHT, LEFT, DOWN, UP}
  always_comb begin
    key_dir = '0;
    if (rx_valid) begin
      case (key_code)
        C_UP:    key_dir = 4'b0001;
        C_DOWN:  key_dir = 4'b0010;
        C_LEFT:  key_dir = 4'b0100;
        C_RIGHT: key_dir = 4'b1000;
        default: key_dir = 4'b0000;
      endcase
    end
  end

  assign mapped = rx_valid && (key_code != C_NONE);
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign pop    = cmd_valid && cmd_ready;
  // A pop frees the slot in the same cycle, so a full queue still accepts.
  assign push   = mapped && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = key_code;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d  = ovf_q || (mapped && !push);
    drop_d = drop_q;
    if (rx_valid && !mapped && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // Opposite direction of bit i is bit i^1 (UP/DOWN, LEFT/RIGHT).
  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < ND; i++) begin
      if (key_dir[i])          hold_d[i] = HW'(HOLD_CYCLES);
      else if (key_dir[i ^ 1]) hold_d[i] = '0;
      else if (hold_q[i] != '0) hold_d[i] = hold_q[i] - HW'(1);
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    for (int i = 0; i < ND; i++) hold_mask[i] = (hold_q[i] != '0);
  end

  assign cmd_valid  = (level_q != '0);
  assign cmd_code   = cmd_valid ? mem_q[rd_ptr_q] : C_NONE;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_uart_key_decoder.sv
// Directed bench for uart_key_decoder; command queue tracked by a scoreboard queue.
module tb_uart_key_decoder;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic       clk, reset;
  logic [7:0] rx_data;
  logic       rx_valid, cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] hold_mask;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  uart_key_decoder #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .hold_mask(hold_mask), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [2:0] sb[$];
  logic       exp_ovf;
  int         exp_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] keymap(input logic [7:0] b);
    case (b)
      8'h77: return 3'd1;
      8'h73: return 3'd2;
      8'h61: return 3'd3;
      8'h64: return 3'd4;
      8'h20, 8'h6A: return 3'd5;
      8'h6B: return 3'd6;
`ifdef KEY_CASE_FOLD_EN
      8'h57: return 3'd1;
      8'h53: return 3'd2;
      8'h41: return 3'd3;
      8'h44: return 3'd4;
      8'h4A: return 3'd5;
      8'h4B: return 3'd6;
`endif
      default: return 3'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx_valid = 1'b0; cmd_ready = 1'b0; rx_data = 8'h00;
    tick(); tick();
    reset = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
    exp_drop = 0;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_code", cmd_code, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_mask", hold_mask, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
  endtask

  // Drive one byte for one edge; rdy optionally pops the head in the same edge.
  task automatic send(input logic [7:0] b, input logic rdy);
    logic [2:0] c;
    c = keymap(b);
    rx_data = b; rx_valid = 1'b1; cmd_ready = rdy;
    if (rdy && sb.size() > 0) begin
      chk("pop_head", cmd_code, sb[0]);
      void'(sb.pop_front());
    end
    if (c != 3'd0) begin
      if (sb.size() < DEPTH) sb.push_back(c);
      else exp_ovf = 1'b1;
    end else if (exp_drop < 255) exp_drop++;
    tick();
    rx_valid = 1'b0; cmd_ready = 1'b0;
    chk("level", fifo_level, sb.size());
    chk("ovf", overflow, exp_ovf);
    chk("drop", drop_count, exp_drop);
  endtask

  task automatic pop1();
    cmd_ready = 1'b1;
    chk("pop_valid", cmd_valid, (sb.size() > 0));
    if (sb.size() > 0) begin
      chk("pop_head", cmd_code, sb[0]);
      void'(sb.pop_front());
    end
    tick();
    cmd_ready = 1'b0;
    chk("pop_level", fifo_level, sb.size());
  endtask

  task automatic drain();
    while (sb.size() > 0) pop1();
    chk("empty_valid", cmd_valid, 0);
    chk("empty_code", cmd_code, 0);
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; cmd_ready = 1'b0; rx_data = 8'h00;
    exp_ovf = 1'b0; exp_drop = 0;
    #2;

    // Basic ordering
    do_reset();
    send(8'h77, 1'b0); send(8'h64, 1'b0); send(8'h20, 1'b0);
    chk("lvl3", fifo_level, 3);
    chk("head_up", cmd_code, 1);
    drain();
    pop1();

    // Overflow and push-while-pop on full
    do_reset();
    send(8'h77, 1'b0); send(8'h73, 1'b0); send(8'h61, 1'b0); send(8'h64, 1'b0);
    chk("full_no_ovf", overflow, 0);
    send(8'h6A, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_lvl", fifo_level, 4);
    send(8'h6B, 1'b1);
    chk("full_pushpop_lvl", fifo_level, 4);
    drain();
    chk("ovf_sticky", overflow, 1);

    // Hold window, single press
    do_reset();
    send(8'h61, 1'b0);
    for (int k = 1; k <= HOLD; k++) begin
      if (k > 1) tick();
      chk("hold_a", hold_mask, 4'b0100);
    end
    tick();
    chk("hold_a_off", hold_mask, 4'b0000);

    // Hold window, re-press at N+5
    do_reset();
    send(8'h61, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("hold_pre", hold_mask, 4'b0100);
      tick();
    end
    send(8'h61, 1'b0);
    for (int k = 6; k <= 13; k++) begin
      if (k > 6) tick();
      chk("hold_re", hold_mask, 4'b0100);
    end
    tick();
    chk("hold_re_off", hold_mask, 4'b0000);

    // Opposite direction cancels
    do_reset();
    send(8'h77, 1'b0);
    chk("hold_w", hold_mask, 4'b0001);
    send(8'h73, 1'b0);
    chk("hold_s", hold_mask, 4'b0010);
    send(8'h64, 1'b0);
    send(8'h61, 1'b0);
    chk("hold_da", hold_mask, 4'b0110);
    send(8'h6B, 1'b0);
    chk("hold_cancel_key", hold_mask, 4'b0110);

    // Unmapped bytes saturate drop_count
    do_reset();
    send(8'h78, 1'b0);
    chk("drop1", drop_count, 1);
    for (int k = 1; k < 300; k++) send(8'h78, 1'b0);
    chk("drop_sat", drop_count, 255);
    chk("drop_empty", cmd_valid, 0);
    chk("drop_mask", hold_mask, 0);
    send(8'h57, 1'b0);
`ifdef KEY_CASE_FOLD_EN
    chk("upper_w", cmd_code, 1);
`else
    chk("upper_w_drop", drop_count, 255);
    chk("upper_w_nopush", cmd_valid, 0);
`endif

    // Asynchronous reset mid-stream
    do_reset();
    send(8'h77, 1'b0); send(8'h73, 1'b0); send(8'h64, 1'b0);
    chk("pre_rst_lvl", fifo_level, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", cmd_valid, 0);
    chk("async_code", cmd_code, 0);
    chk("async_level", fifo_level, 0);
    chk("async_mask", hold_mask, 0);
    chk("async_ovf", overflow, 0);
    chk("async_drop", drop_count, 0);
    tick();
    reset = 1'b1;
    sb.delete(); exp_ovf = 1'b0; exp_drop = 0;
    send(8'h6B, 1'b0);
    chk("post_rst_code", cmd_code, 6);
    chk("post_rst_lvl", fifo_level, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
